// File: rtl/sdram_bram_pkg.sv
// Shared state encoding and refresh timing for the BRAM-backed SDRAM responder.
package sdram_bram_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WORK    = 2'd1;
   localparam logic [1:0] ST_DONE_RD = 2'd2;
   localparam logic [1:0] ST_REFRESH = 2'd3;

   localparam int unsigned REFRESH_PERIOD = 1024;
   localparam int unsigned REFRESH_CYCLES = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_bram_responder_if.sv
// User-side SDRAM request/response bundle shared by the GPMC bridge and its responder.
interface sdram_bram_responder_if #(
   parameter int unsigned ADDR_WIDTH = 25,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_enable;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_enable;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_ready;
   logic                  busy;
   logic                  ack;
   logic                  collision;

   modport master (
      output wr_addr, wr_enable, wr_data, rd_addr, rd_enable,
      input  rd_data, rd_ready, busy, ack, collision
   );

   modport slave (
      input  wr_addr, wr_enable, wr_data, rd_addr, rd_enable,
      output rd_data, rd_ready, busy, ack, collision
   );
endinterface

// File: rtl/sdram_bram_responder_bram_sp.sv
// Single-port synchronous RAM, registered read, write-enable; shaped to infer iCE40 block RAM.
module bram_sp #(
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH     = 8
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic                      we,
   input  logic [MEM_ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]     din,
   output logic [DATA_WIDTH-1:0]     dout
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << MEM_ADDR_WIDTH)-1];

   // dout only moves on a read access, so it holds across writes and idle cycles
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= din;
         else    dout      <= mem[addr];
      end
   end

endmodule

// File: rtl/sdram_bram_responder.sv
// SDRAM-controller stand-in backed by block RAM with programmable latency.
// Optional periodic refresh stall: define SDRAM_REFRESH_STALL_EN.
module sdram_bram_responder
   import sdram_bram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 25,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   parameter int unsigned WR_LATENCY     = 2,
   parameter int unsigned RD_LATENCY     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sdram_bram_responder_if.slave bus
);

   localparam int unsigned MAX_LAT = max_u(WR_LATENCY, RD_LATENCY);
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   logic [1:0]                state;
   logic [CNT_W-1:0]          cnt;
   logic                      op_wr;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [DATA_WIDTH-1:0]     ram_q;
   logic                      rd_valid;
   logic                      ack_q, busy_q, rd_ready_q, collision_q;

   logic idle_like, req, accept, finish;
   logic refresh_go, ref_done;

   assign idle_like = (state == ST_IDLE) || (state == ST_DONE_RD);
   assign req       = bus.wr_enable | bus.rd_enable;
   assign accept    = idle_like & req & ~refresh_go;
   assign finish    = (state == ST_WORK) && (cnt == '0);

   // Upper address bits alias onto the RAM; they are intentionally ignored
   logic unused_addr_hi;
   assign unused_addr_hi = ^{bus.wr_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                             bus.rd_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

`ifdef SDRAM_REFRESH_STALL_EN
   localparam int unsigned TICK_W = $clog2(REFRESH_PERIOD);
   localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES);

   logic [TICK_W-1:0] ref_tick;
   logic [REF_W-1:0]  ref_left;
   logic              ref_pending, ref_due;

   // A refresh that falls due mid-operation stays pending until the responder is idle
   assign ref_due    = ref_pending | (ref_tick == '1);
   assign refresh_go = idle_like & ref_due;
   assign ref_done   = (state == ST_REFRESH) && (ref_left == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_tick    <= '0;
         ref_pending <= 1'b0;
         ref_left    <= '0;
      end else begin
         ref_tick    <= ref_tick + 1'b1;
         ref_pending <= ref_due & ~refresh_go;
         if (refresh_go)                ref_left <= REF_W'(REFRESH_CYCLES - 1);
         else if (state == ST_REFRESH)  ref_left <= ref_left - 1'b1;
      end
   end
`else
   assign refresh_go = 1'b0;
   assign ref_done   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         op_wr       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         rd_valid    <= 1'b0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         rd_ready_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         ack_q      <= accept;
         rd_ready_q <= finish & ~op_wr;
         if (finish && !op_wr) rd_valid <= 1'b1;
         if (accept && bus.wr_enable && bus.rd_enable) collision_q <= 1'b1;

         case (state)
            ST_IDLE, ST_DONE_RD: begin
               if (refresh_go) begin
                  state  <= ST_REFRESH;
                  busy_q <= 1'b1;
               end else if (req) begin
                  // Write wins a simultaneous request; the read is dropped
                  state  <= ST_WORK;
                  busy_q <= 1'b1;
                  op_wr  <= bus.wr_enable;
                  data_q <= bus.wr_data;
                  if (bus.wr_enable) begin
                     addr_q <= bus.wr_addr[MEM_ADDR_WIDTH-1:0];
                     cnt    <= CNT_W'(WR_LATENCY - 1);
                  end else begin
                     addr_q <= bus.rd_addr[MEM_ADDR_WIDTH-1:0];
                     cnt    <= CNT_W'(RD_LATENCY - 1);
                  end
               end
            end
            ST_WORK: begin
               if (cnt == '0) begin
                  busy_q <= 1'b0;
                  state  <= op_wr ? ST_IDLE : ST_DONE_RD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_REFRESH: begin
               if (ref_done) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
         endcase
      end
   end

   bram_sp #(
      .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH)
   ) u_ram (
      .clk  (clk),
      .en   (finish),
      .we   (op_wr),
      .addr (addr_q),
      .din  (data_q),
      .dout (ram_q)
   );

   // RAM output register has no reset, so rd_data is masked until the first read lands
   assign bus.rd_data   = rd_valid ? ram_q : '0;
   assign bus.rd_ready  = rd_ready_q;
   assign bus.busy      = busy_q;
   assign bus.ack       = ack_q;
   assign bus.collision = collision_q;

endmodule
